// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I field-to-word encoder with range/alignment checks, an error-halt FSM
// and a small output FIFO that tags each word with its sequential load address.
module rv32i_instr_encoder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH       = 2,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        clear_err_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [6:0]  in_opcode_i,
   input  logic [4:0]  in_rd_i,
   input  logic [4:0]  in_rs1_i,
   input  logic [4:0]  in_rs2_i,
   input  logic [2:0]  in_funct3_i,
   input  logic [6:0]  in_funct7_i,
   input  logic [31:0] in_imm_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o,
   output logic        halted_o,
   output logic [15:0] enc_count_o,
   output logic [7:0]  err_count_o
);

   // state   | meaning
   // IDLE    | waiting for start, no tuples accepted
   // RUN     | accepting and encoding tuples
   // HALT    | stopped after an encoding error, FIFO still drains

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t        state_q;
   logic          halted_q;
   logic [31:0]   addr_q;
   logic [15:0]   enc_count_q;
   logic [7:0]    err_count_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   addr_mem_q  [DEPTH];
   logic          err_mem_q   [DEPTH];

   logic [31:0] enc_word;
   logic        enc_err;
   logic        push;
   logic        pop;

   always_comb begin
      enc_word = NOP;
      enc_err  = 1'b0;
      case (in_opcode_i)
         7'b0110011:
            enc_word = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
         7'b0010011: begin
            if (in_funct3_i == 3'b001 || in_funct3_i == 3'b101) begin
               enc_word = {in_funct7_i, in_imm_i[4:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
               enc_err  = |in_imm_i[31:5];
            end else begin
               enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
               enc_err  = in_imm_i[31:11] != {21{in_imm_i[11]}};
            end
         end
         7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
            enc_word = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_opcode_i};
            enc_err  = in_imm_i[31:11] != {21{in_imm_i[11]}};
         end
         7'b0100011: begin
            enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], in_opcode_i};
            enc_err  = in_imm_i[31:11] != {21{in_imm_i[11]}};
         end
         7'b1100011: begin
            enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                        in_imm_i[4:1], in_imm_i[11], in_opcode_i};
            enc_err  = (in_imm_i[31:12] != {20{in_imm_i[12]}}) || in_imm_i[0];
         end
         7'b0110111, 7'b0010111: begin
            enc_word = {in_imm_i[31:12], in_rd_i, in_opcode_i};
            enc_err  = |in_imm_i[11:0];
         end
         7'b1101111: begin
            enc_word = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12],
                        in_rd_i, in_opcode_i};
            enc_err  = (in_imm_i[31:20] != {12{in_imm_i[20]}}) || in_imm_i[0];
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) begin
         enc_word = NOP;
      end
   end

   // A full FIFO that is popping this cycle still takes a new word, so no bubble appears
   assign in_ready_o  = (state_q == ST_RUN) && ((count_q < DEPTH_C) || out_ready_i);
   assign push        = in_valid_i && in_ready_o;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o && out_ready_i;

   assign out_instr_o = instr_mem_q[rd_ptr_q];
   assign out_addr_o  = addr_mem_q[rd_ptr_q];
   assign out_err_o   = err_mem_q[rd_ptr_q];
   assign halted_o    = halted_q;
   assign enc_count_o = enc_count_q;
   assign err_count_o = err_count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               halted_q <= 1'b0;
               if (start_i) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (push && enc_err && STOP_ON_ERR) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end
            end
            ST_HALT: begin
               if (clear_err_i) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q      <= BASE_ADDR;
         enc_count_q <= '0;
         err_count_q <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            addr_mem_q[i]  <= '0;
            err_mem_q[i]   <= 1'b0;
         end
      end else begin
         if (state_q == ST_IDLE && start_i) begin
            addr_q <= BASE_ADDR;
         end
         if (push) begin
            instr_mem_q[wr_ptr_q] <= enc_word;
            addr_mem_q[wr_ptr_q]  <= addr_q;
            err_mem_q[wr_ptr_q]   <= enc_err;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
            addr_q                <= addr_q + 32'd4;
            enc_count_q           <= enc_count_q + 1'b1;
            if (enc_err && err_count_q != 8'hFF) begin
               err_count_q <= err_count_q + 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed cases plus random legal tuples,
// each output word decoded back into fields and checked against the issued tuple.
module tb_rv32i_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clear_err = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic        halted;
   logic [15:0] enc_count;
   logic [7:0]  err_count;

   rv32i_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2), .STOP_ON_ERR(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_err_i(clear_err),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_opcode_i(in_opcode), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
      .in_funct3_i(in_funct3), .in_funct7_i(in_funct7), .in_imm_i(in_imm),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
      .out_addr_o(out_addr), .out_err_o(out_err), .halted_o(halted),
      .enc_count_o(enc_count), .err_count_o(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      bit          err;
      logic [31:0] addr;
      bit          has_word;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_addr = BASE;
   int          n_xfer = 0;
   int          n_err = 0;

   localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6, F_BAD = 7;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int fmt_of(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'h33: return F_R;
         7'h13: return (f3 == 3'd1 || f3 == 3'd5) ? F_SH : F_I;
         7'h03, 7'h67, 7'h73, 7'h0F: return F_I;
         7'h23: return F_S;
         7'h63: return F_B;
         7'h37, 7'h17: return F_U;
         7'h6F: return F_J;
         default: return F_BAD;
      endcase
   endfunction

   // Legality by numeric range of the signed immediate
   function automatic bit model_err(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
      int v;
      v = $signed(imm);
      case (fmt_of(op, f3))
         F_R:       return 1'b0;
         F_I, F_S:  return (v < -2048) || (v > 2047);
         F_SH:      return imm > 32'd31;
         F_B:       return (v < -4096) || (v > 4095) || (v % 2 != 0);
         F_U:       return (imm % 4096) != 0;
         F_J:       return (v < -(1 << 20)) || (v > (1 << 20) - 1) || (v % 2 != 0);
         default:   return 1'b1;
      endcase
   endfunction

   task automatic check_word(input exp_t e);
      logic [31:0] i;
      logic [31:0] imm_d;
      i = out_instr;
      chk("addr", out_addr, e.addr);
      chk("err_flag", {31'd0, out_err}, {31'd0, e.err});
      if (e.err) begin
         chk("err_nop", i, 32'h0000_0013);
         return;
      end
      if (e.has_word) chk("word", i, e.word);
      chk("opcode", {25'd0, i[6:0]}, {25'd0, e.op});
      case (fmt_of(e.op, e.f3))
         F_R: begin
            chk("r_fields", {i[31:25], i[24:20], i[19:15], i[14:12], i[11:7]},
                {e.f7, e.rs2, e.rs1, e.f3, e.rd});
         end
         F_I: begin
            imm_d = {{20{i[31]}}, i[31:20]};
            chk("i_fields", {i[19:15], i[14:12], i[11:7]}, {e.rs1, e.f3, e.rd});
            chk("i_imm", imm_d, e.imm);
         end
         F_SH: begin
            chk("sh_fields", {i[31:25], i[19:15], i[14:12], i[11:7]}, {e.f7, e.rs1, e.f3, e.rd});
            chk("sh_amt", {27'd0, i[24:20]}, e.imm);
         end
         F_S: begin
            imm_d = {{20{i[31]}}, i[31:25], i[11:7]};
            chk("s_fields", {i[24:20], i[19:15], i[14:12]}, {e.rs2, e.rs1, e.f3});
            chk("s_imm", imm_d, e.imm);
         end
         F_B: begin
            imm_d = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            chk("b_fields", {i[24:20], i[19:15], i[14:12]}, {e.rs2, e.rs1, e.f3});
            chk("b_imm", imm_d, e.imm);
         end
         F_U: begin
            chk("u_rd", {27'd0, i[11:7]}, {27'd0, e.rd});
            chk("u_imm", {i[31:12], 12'd0}, e.imm);
         end
         F_J: begin
            imm_d = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            chk("j_rd", {27'd0, i[11:7]}, {27'd0, e.rd});
            chk("j_imm", imm_d, e.imm);
         end
         default: chk("bad_fmt_without_err", 32'd1, 32'd0);
      endcase
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected none", out_instr);
            end else begin
               e = sb.pop_front();
               check_word(e);
            end
         end
      end
   end

   function automatic exp_t make_exp(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm, input bit has_word, input logic [31:0] word);
      exp_t e;
      e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7; e.imm = imm;
      e.err = model_err(op, f3, imm);
      e.addr = model_addr;
      e.has_word = has_word;
      e.word = word;
      return e;
   endfunction

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
   endtask

   task automatic accept_record();
      exp_t e;
      e = make_exp(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, 1'b0, 32'd0);
      sb.push_back(e);
      model_addr += 32'd4;
      n_xfer++;
      if (e.err) n_err++;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input bit has_word, input logic [31:0] word);
      int  t;
      bit  done;
      exp_t e;
      drive(op, rd, rs1, rs2, f3, f7, imm);
      t = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
         end else begin
            t++;
            if (t > 200) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: got in_ready=0 expected 1");
               in_valid = 1'b0;
               return;
            end
         end
      end
      e = make_exp(op, rd, rs1, rs2, f3, f7, imm, has_word, word);
      sb.push_back(e);
      model_addr += 32'd4;
      n_xfer++;
      if (e.err) n_err++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      model_addr = BASE;
      n_xfer = 0;
      n_err = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      clear_err = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain", sb.size(), 32'd0);
   endtask

   task automatic rand_legal();
      logic [6:0] ops[11];
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] imm;
      int v;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      op = ops[$urandom_range(0, 10)];
      f3 = 3'($urandom);
      case (fmt_of(op, f3))
         F_I, F_S: begin v = int'($urandom_range(0, 4095)) - 2048; imm = v; end
         F_SH:     imm = $urandom_range(0, 31);
         F_B:      begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; imm = v; end
         F_U:      imm = $urandom & 32'hFFFF_F000;
         F_J:      begin v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2; imm = v; end
         default:  imm = $urandom;
      endcase
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), f3, 7'($urandom), imm, 1'b0, 32'd0);
   endtask

   bit rand_done = 0;

   initial begin : stim
      int c0;
      do_reset();
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);

      // First word and one-cycle latency
      @(posedge clk); #1;
      out_ready = 1'b1;
      pulse_start();
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      @(negedge clk);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      drain();

      // Back-to-back at full throughput
      do_reset();
      out_ready = 1'b1;
      pulse_start();
      c0 = $time;
      send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
      send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b1, 32'h0010_00EF);
      send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
      chk("throughput_cycles", ($time - c0) / 10, 32'd4);
      drain();

      // Errors halt the encoder until clear_err
      do_reset();
      out_ready = 1'b1;
      pulse_start();
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
      @(negedge clk);
      chk("halted_after_err", {31'd0, halted}, 32'd1);
      chk("in_ready_halted", {31'd0, in_ready}, 32'd0);
      chk("err_count_one", {24'd0, err_count}, 32'd1);
      @(posedge clk); #1;
      pulse_clear();
      chk("unhalted", {31'd0, halted}, 32'd0);
      send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd100, 1'b1, 32'h0641_8113);
      send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0);
      @(negedge clk);
      chk("halted_beq_odd", {31'd0, halted}, 32'd1);
      @(posedge clk); #1;
      pulse_clear();
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
      @(posedge clk); #1;
      pulse_clear();
      drain();
      chk("err_count_three", {24'd0, err_count}, 32'd3);
      chk("enc_count_err", {16'd0, enc_count}, 32'd4);

      // Backpressure: two fit, the third enters as the first leaves
      do_reset();
      out_ready = 1'b0;
      pulse_start();
      send(7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b1, 32'h4052_01B3);
      send(7'h17, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 1'b1, 32'hFFFF_F317);
      drive(7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_blocks", {31'd0, in_ready}, 32'd0);
      end
      chk("enc_count_full", {16'd0, enc_count}, 32'd2);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("accept_on_pop", {31'd0, in_ready & out_valid}, 32'd1);
      if (in_ready) accept_record();
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Reset with a full FIFO discards contents
      out_ready = 1'b0;
      send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0);
      send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'd0);
      do_reset();
      @(negedge clk);
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_enc_count", {16'd0, enc_count}, 32'd0);
      chk("rst_mid_idle_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      pulse_start();
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      drain();

      // Random legal tuples with random backpressure
      do_reset();
      pulse_start();
      fork
         begin
            for (int n = 0; n < 10000; n++) rand_legal();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("rand_enc_count", {16'd0, enc_count}, 32'(n_xfer % 65536));
      chk("rand_err_count", {24'd0, err_count}, 32'(n_err));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
